// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall controller for the 5-stage datapath.
// Tracks EX/MEM/WB destination registers and keeps a saturating stall counter.
module fwd_hazard_unit #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic [ADDR_W-1:0] rd;
        logic              reg_write;
        logic              mem_read;
    } ex_entry_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic              reg_write;
    } wr_entry_t;

    ex_entry_t ex_q;
    ex_entry_t ex_d;
    wr_entry_t mem_q;
    wr_entry_t wb_q;
    logic      load_use;

    // A stage is a forwarding source only if it really writes a non-zero register.
    function automatic logic writes_reg(input wr_entry_t e, input logic [ADDR_W-1:0] src);
        return e.valid && e.reg_write && (e.rd != '0) && (e.rd == src);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] src,
                                           input wr_entry_t mem_e,
                                           input wr_entry_t wb_e);
        logic [1:0] sel;
        sel = FWD_RF;
        if (writes_reg(mem_e, src)) begin
            sel = FWD_MEM;
        end else if (writes_reg(wb_e, src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // Load in EX feeding the instruction in ID; flush overrides it.
    always_comb begin
        load_use = 1'b0;
        ex_d     = '0;
        if (ex_q.valid && ex_q.mem_read && ex_q.reg_write && (ex_q.rd != '0) && id_valid &&
            ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2))) begin
            load_use = ~flush;
        end
        if (!flush && !load_use) begin
            ex_d.valid     = id_valid;
            ex_d.rs1       = id_rs1;
            ex_d.rs2       = id_rs2;
            ex_d.rd        = id_rd;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
        end
    end

    assign stall = load_use;
    assign fwd_a = ex_q.valid ? fwd_sel(ex_q.rs1, mem_q, wb_q) : FWD_RF;
    assign fwd_b = ex_q.valid ? fwd_sel(ex_q.rs2, mem_q, wb_q) : FWD_RF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q            <= ex_d;
            mem_q.valid     <= ex_q.valid;
            mem_q.rd        <= ex_q.rd;
            mem_q.reg_write <= ex_q.reg_write;
            wb_q            <= mem_q;
        end
    end

    // Saturating performance counter of stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (load_use && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit with a queue-based scoreboard.
module tb_fwd_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       stall;
    logic [3:0] stall_count;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       st;
        logic [3:0] cnt;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk;
    int   n_fail;

    fwd_hazard_unit #(.ADDR_W(5), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall        (stall),
        .stall_count  (stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One cycle: drive ID/control just after the edge and queue the expected outputs for it.
    task automatic cyc(input int r, input int v, input int rs1, input int rs2, input int rd,
                       input int rw, input int mr, input int fl,
                       input int ea, input int eb, input int es, input int ec, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n        = 1'(r);
        id_valid     = 1'(v);
        id_rs1       = 5'(rs1);
        id_rs2       = 5'(rs2);
        id_rd        = 5'(rd);
        id_reg_write = 1'(rw);
        id_mem_read  = 1'(mr);
        flush        = 1'(fl);
        e.a    = 2'(ea);
        e.b    = 2'(eb);
        e.st   = 1'(es);
        e.cnt  = 4'(ec);
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic nop(input int ea, input int eb, input int ec, input string nm);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, ea, eb, 0, ec, nm);
    endtask

    // Monitor: compare DUT outputs against the queued expectation mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_chk++;
            if ({fwd_a, fwd_b, stall, stall_count} !== {e.a, e.b, e.st, e.cnt}) begin
                n_fail++;
                $display("FAIL %s: got fwd_a=%b fwd_b=%b stall=%b cnt=%0d, want fwd_a=%b fwd_b=%b stall=%b cnt=%0d",
                         e.name, fwd_a, fwd_b, stall, stall_count, e.a, e.b, e.st, e.cnt);
            end
        end
    end

    initial begin
        int c;
        n_chk        = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        id_valid     = 1'b0;
        id_rs1       = '0;
        id_rs2       = '0;
        id_rd        = '0;
        id_reg_write = 1'b0;
        id_mem_read  = 1'b0;
        flush        = 1'b0;

        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset_idle");
        nop(0, 0, 0, "release");

        // EX/MEM forward
        cyc(1, 1, 1, 2, 5, 1, 0, 0, 0, 0, 0, 0, "add_x5_id");
        cyc(1, 1, 5, 6, 8, 1, 0, 0, 0, 0, 0, 0, "sub_id");
        nop(1, 0, 0, "exmem_fwd");
        nop(0, 0, 0, "idle1");

        // MEM beats WB
        cyc(1, 1, 1, 2, 7, 1, 0, 0, 0, 0, 0, 0, "w7a");
        cyc(1, 1, 3, 4, 7, 1, 0, 0, 0, 0, 0, 0, "w7b");
        cyc(1, 1, 7, 7, 9, 1, 0, 0, 0, 0, 0, 0, "reader_id");
        nop(1, 1, 0, "prio_mem");

        // One unrelated instruction in between: WB forward
        cyc(1, 1, 1, 2, 7, 1, 0, 0, 0, 0, 0, 0, "w7c");
        cyc(1, 1, 1, 2, 7, 1, 0, 0, 0, 0, 0, 0, "w7d");
        cyc(1, 1, 11, 12, 10, 1, 0, 0, 0, 0, 0, 0, "unrel");
        cyc(1, 1, 7, 7, 9, 1, 0, 0, 0, 0, 0, 0, "reader2_id");
        nop(2, 2, 0, "prio_wb");

        // Load-use: one stall cycle, then WB forward
        cyc(1, 1, 1, 0, 4, 1, 1, 0, 0, 0, 0, 0, "lw_x4_id");
        cyc(1, 1, 3, 4, 6, 1, 0, 0, 0, 0, 1, 0, "load_use_stall");
        cyc(1, 1, 3, 4, 6, 1, 0, 0, 0, 0, 0, 1, "load_use_bubble");
        nop(0, 2, 1, "lw_fwd_wb");

        // x0 neither stalls nor forwards
        cyc(1, 1, 1, 2, 0, 1, 1, 0, 0, 0, 0, 1, "lw_x0_id");
        cyc(1, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 1, "x0_no_stall");
        nop(0, 0, 1, "x0_no_fwd");

        // Flush beats stall
        cyc(1, 1, 1, 2, 4, 1, 1, 0, 0, 0, 0, 1, "lw_flush_id");
        cyc(1, 1, 4, 5, 7, 1, 0, 1, 0, 0, 0, 1, "flush_no_stall");
        nop(0, 0, 1, "flush_bubble");

        // Asynchronous reset with x3 writers in flight
        cyc(1, 1, 1, 2, 3, 1, 0, 0, 0, 0, 0, 1, "w3_id");
        cyc(1, 1, 3, 3, 3, 1, 0, 0, 0, 0, 0, 1, "r3_id");
        cyc(1, 1, 3, 3, 3, 1, 0, 0, 1, 1, 0, 1, "mem_fwd_x3");
        cyc(0, 1, 3, 3, 8, 1, 0, 0, 0, 0, 0, 0, "async_reset");
        cyc(0, 1, 3, 3, 8, 1, 0, 0, 0, 0, 0, 0, "reset_hold");
        cyc(1, 1, 3, 3, 8, 1, 0, 0, 0, 0, 0, 0, "reset_release");
        nop(0, 0, 0, "no_stale_fwd");

        // Back-to-back load-use pairs: counter saturates at 15
        for (int k = 0; k < 20; k++) begin
            c = (k > 15) ? 15 : k;
            cyc(1, 1, 1, 2, 4, 1, 1, 0, 0, (k > 0) ? 2 : 0, 0, c, "sat_lw");
            cyc(1, 1, 3, 4, 6, 1, 0, 0, 0, 0, 1, c, "sat_stall");
            c = (k + 1 > 15) ? 15 : k + 1;
            cyc(1, 1, 3, 4, 6, 1, 0, 0, 0, 0, 0, c, "sat_bubble");
        end
        nop(0, 2, 15, "sat_hold");

        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
